// File: rtl/membus_sram_resp_if.sv
// -----------------------------------------------------------------------------
// membus_sram_resp_if
// Requester-side MemBus bundle between an arbiter (master) and the SRAM
// responder (slave).
//   addr  [22:0] byte address (bit 0 unused by the responder)
//   dati  [15:0] write data toward memory
//   dato  [15:0] registered read data toward the requester
//   oe           read request level
//   we_lo        low-byte write request level
//   we_hi        high-byte write request level
//   ack          one-cycle completion pulse
//   busy         responder is in the middle of an access
// -----------------------------------------------------------------------------
interface membus_if;
  logic [22:0] addr;
  logic [15:0] dati;
  logic [15:0] dato;
  logic        oe;
  logic        we_lo;
  logic        we_hi;
  logic        ack;
  logic        busy;

  modport master (output addr, dati, oe, we_lo, we_hi, input dato, ack, busy);
  modport slave  (input addr, dati, oe, we_lo, we_hi, output dato, ack, busy);
endinterface

// File: rtl/membus_sram_resp.sv
// -----------------------------------------------------------------------------
// membus_sram_resp
// Memory-side MemBus responder driving one asynchronous 16-bit SRAM. Each
// request level seen in IDLE starts a timed read or write; all state and all
// outputs update on the falling clock edge.
// Ports:
//   clk        system clock (state changes on negedge)
//   rst        synchronous active-high reset
//   bus        membus_if.slave: addr/dati/oe/we_lo/we_hi in, dato/ack/busy out
//   ram_addr   SRAM word address (addr[22:1], latched at access start)
//   ram_dq_i   SRAM read data
//   ram_dq_o   SRAM write data (latched dati)
//   ram_dq_oe  data-bus output enable
//   ram_ce_n / ram_oe_n / ram_we_n / ram_ub_n / ram_lb_n  active-low SRAM pins
// -----------------------------------------------------------------------------
module membus_sram_resp #(
  parameter int unsigned RD_WAIT = 32'd1,
  parameter int unsigned WR_WAIT = 32'd1,
  parameter int unsigned RECOVER = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  membus_if.slave     bus,
  output logic [21:0] ram_addr,
  input  logic [15:0] ram_dq_i,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe,
  output logic        ram_ce_n,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  output logic        ram_ub_n,
  output logic        ram_lb_n
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] RD_LOAD  = CW'(RD_WAIT);
  localparam logic [CW-1:0] WR_LOAD  = CW'(WR_WAIT);
  // REC counts down to zero, so it is loaded with RECOVER-1.
  localparam logic [CW-1:0] REC_LOAD = (RECOVER > 32'd0) ? CW'(RECOVER - 32'd1) : {CW{1'b0}};
  localparam bit            HAS_REC  = (RECOVER > 32'd0);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WR    = 3'd2,
    WHOLD = 3'd3,
    REC   = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [1:0]    be_r, be_s;        // {high, low} byte write enables
  logic          wr_req_s, start_s, last_s;
  logic          addr_unused_s;

  logic [15:0]   dato_r, dato_s;
  logic [21:0]   addr_r, addr_s;
  logic [15:0]   dq_o_r, dq_o_s;
  logic          ack_r, ack_s;
  logic          busy_r, busy_s;
  logic          dq_oe_r, dq_oe_s;
  logic          ce_n_r, ce_n_s;
  logic          oe_n_r, oe_n_s;
  logic          we_n_r, we_n_s;
  logic          ub_n_r, ub_n_s;
  logic          lb_n_r, lb_n_s;

  // Byte address bit 0 has no meaning on a 16-bit word SRAM.
  assign addr_unused_s = bus.addr[0];

  assign wr_req_s = bus.we_lo | bus.we_hi;
  assign start_s  = (state_r == IDLE) & (wr_req_s | bus.oe);
  assign last_s   = (cnt_r == 8'd0);

  // State register: FSM state and the shared wait/recovery counter.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic; a write strobe takes priority over a simultaneous read.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (wr_req_s) begin
          state_s = WR;
          cnt_s   = WR_LOAD;
        end else if (bus.oe) begin
          state_s = RD;
          cnt_s   = RD_LOAD;
        end else begin
          state_s = IDLE;
          cnt_s   = cnt_r;
        end
      end
      RD: begin
        if (last_s) begin
          state_s = HAS_REC ? REC : IDLE;
          cnt_s   = REC_LOAD;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      WR: begin
        if (last_s) begin
          state_s = WHOLD;
          cnt_s   = 8'd0;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      WHOLD: begin
        state_s = HAS_REC ? REC : IDLE;
        cnt_s   = REC_LOAD;
      end
      REC: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r - 8'd1;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 8'd0;
      end
    endcase
  end

  // Output logic: pin values follow the state being entered so they change on
  // the same edge as the state. dq_oe is only ever set in WR/WHOLD and oe_n is
  // only ever low in RD, so the data bus can never be driven from both sides.
  always_comb begin
    be_s    = (state_r == IDLE) ? {bus.we_hi, bus.we_lo} : be_r;
    ce_n_s  = 1'b1;
    oe_n_s  = 1'b1;
    we_n_s  = 1'b1;
    ub_n_s  = 1'b1;
    lb_n_s  = 1'b1;
    dq_oe_s = 1'b0;
    case (state_s)
      RD: begin
        ce_n_s = 1'b0;
        oe_n_s = 1'b0;
        ub_n_s = 1'b0;
        lb_n_s = 1'b0;
      end
      WR: begin
        ce_n_s  = 1'b0;
        we_n_s  = 1'b0;
        dq_oe_s = 1'b1;
        ub_n_s  = ~be_s[1];
        lb_n_s  = ~be_s[0];
      end
      WHOLD: begin
        ce_n_s  = 1'b0;
        dq_oe_s = 1'b1;
        ub_n_s  = ~be_s[1];
        lb_n_s  = ~be_s[0];
      end
      default: begin
        ce_n_s = 1'b1;
      end
    endcase
    ack_s  = ((state_r == RD) | (state_r == WR)) & last_s;
    busy_s = (state_s != IDLE);
    dato_s = ((state_r == RD) & last_s) ? ram_dq_i : dato_r;
    addr_s = start_s ? bus.addr[22:1] : addr_r;
    dq_o_s = start_s ? bus.dati : dq_o_r;
  end

  // Output registers; reset drops every pin inactive and suppresses ack.
  always_ff @(negedge clk) begin
    if (rst) begin
      dato_r  <= 16'd0;
      addr_r  <= 22'd0;
      dq_o_r  <= 16'd0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      dq_oe_r <= 1'b0;
      ce_n_r  <= 1'b1;
      oe_n_r  <= 1'b1;
      we_n_r  <= 1'b1;
      ub_n_r  <= 1'b1;
      lb_n_r  <= 1'b1;
      be_r    <= 2'b00;
    end else begin
      dato_r  <= dato_s;
      addr_r  <= addr_s;
      dq_o_r  <= dq_o_s;
      ack_r   <= ack_s;
      busy_r  <= busy_s;
      dq_oe_r <= dq_oe_s;
      ce_n_r  <= ce_n_s;
      oe_n_r  <= oe_n_s;
      we_n_r  <= we_n_s;
      ub_n_r  <= ub_n_s;
      lb_n_r  <= lb_n_s;
      be_r    <= be_s;
    end
  end

  assign bus.dato  = dato_r;
  assign bus.ack   = ack_r;
  assign bus.busy  = busy_r;
  assign ram_addr  = addr_r;
  assign ram_dq_o  = dq_o_r;
  assign ram_dq_oe = dq_oe_r;
  assign ram_ce_n  = ce_n_r;
  assign ram_oe_n  = oe_n_r;
  assign ram_we_n  = we_n_r;
  assign ram_ub_n  = ub_n_r;
  assign ram_lb_n  = lb_n_r;

endmodule

// File: tb/tb_membus_sram_resp.sv
// -----------------------------------------------------------------------------
// tb_membus_sram_resp
// Drives two responders (default timing, and RD_WAIT=3/RECOVER=2) against a
// behavioural SRAM. A reference memory updated from the requests the bench
// issues predicts read data; timing expectations come from the wait/recovery
// cycle counts. Inputs change on posedge, the DUT updates on negedge, outputs
// are sampled on posedge.
// -----------------------------------------------------------------------------
module tb_membus_sram_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  membus_if bus();
  membus_if bus2();

  logic [21:0] ram_addr, ram_addr2;
  logic [15:0] ram_dq_i, ram_dq_o, ram_dq_i2, ram_dq_o2;
  logic        ram_dq_oe, ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n;
  logic        ram_dq_oe2, ram_ce_n2, ram_oe_n2, ram_we_n2, ram_ub_n2, ram_lb_n2;

  membus_sram_resp #(.RD_WAIT(1), .WR_WAIT(1), .RECOVER(0)) u_dut (
    .clk(clk), .rst(rst), .bus(bus),
    .ram_addr(ram_addr), .ram_dq_i(ram_dq_i), .ram_dq_o(ram_dq_o), .ram_dq_oe(ram_dq_oe),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .ram_ub_n(ram_ub_n), .ram_lb_n(ram_lb_n)
  );

  membus_sram_resp #(.RD_WAIT(3), .WR_WAIT(1), .RECOVER(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2),
    .ram_addr(ram_addr2), .ram_dq_i(ram_dq_i2), .ram_dq_o(ram_dq_o2), .ram_dq_oe(ram_dq_oe2),
    .ram_ce_n(ram_ce_n2), .ram_oe_n(ram_oe_n2), .ram_we_n(ram_we_n2),
    .ram_ub_n(ram_ub_n2), .ram_lb_n(ram_lb_n2)
  );

  // Behavioural SRAM for the default instance (word index = ram_addr[7:0]).
  logic [15:0] sram_mem [0:255];
  logic [15:0] ref_mem  [0:255];
  int checks = 0;
  int errors = 0;
  int contention_cnt = 0;

  assign ram_dq_i  = (!ram_ce_n && !ram_oe_n) ? sram_mem[ram_addr[7:0]] : 16'hDEAD;
  // Second instance reads a fixed address-derived pattern.
  assign ram_dq_i2 = (!ram_ce_n2 && !ram_oe_n2) ? (ram_addr2[15:0] ^ 16'hA5C3) : 16'hDEAD;

  // SRAM write: bytes are stored on every edge where CE and WE are both low.
  always @(negedge clk) begin
    if (ram_ce_n === 1'b0 && ram_we_n === 1'b0) begin
      if (ram_lb_n === 1'b0) sram_mem[ram_addr[7:0]][7:0]  <= ram_dq_o[7:0];
      if (ram_ub_n === 1'b0) sram_mem[ram_addr[7:0]][15:8] <= ram_dq_o[15:8];
    end
  end

  // Bus contention monitor on both instances.
  always @(posedge clk) begin
    if ((ram_oe_n === 1'b0 && ram_dq_oe === 1'b1) || (ram_oe_n2 === 1'b0 && ram_dq_oe2 === 1'b1))
      contention_cnt <= contention_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    int acks;
    rst = 1'b1;
    bus.oe = 1'b1; bus.addr = 23'h000124;
    repeat (3) @(posedge clk);
    checks++;
    if ({ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_pins: got %b expected 11111", {ram_ce_n, ram_oe_n, ram_we_n, ram_ub_n, ram_lb_n});
    end
    checks++;
    if ({ram_dq_oe, bus.busy, bus.ack} !== 3'b000 || bus.dato !== 16'h0000 || ram_addr !== 22'h0) begin
      errors++; $display("FAIL reset_regs: dq_oe/busy/ack=%b dato=%h addr=%h expected 000/0000/0", {ram_dq_oe, bus.busy, bus.ack}, bus.dato, ram_addr);
    end
    bus.oe = 1'b0;
    rst = 1'b0;
    acks = 0;
    repeat (4) begin
      @(posedge clk);
      if (bus.ack !== 1'b0 || bus.busy !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL reset_release: %0d cycles with ack/busy, expected 0", acks);
    end
  endtask

  task automatic test_read();
    sram_mem[8'h92] <= 16'hBEEF;
    ref_mem[8'h92] = 16'hBEEF;
    bus.addr = 23'h000124; bus.oe = 1'b1;
    @(posedge clk); // after E0
    checks++;
    if (ram_addr !== 22'h000092 || ram_oe_n !== 1'b0 || ram_ce_n !== 1'b0 || bus.ack !== 1'b0) begin
      errors++; $display("FAIL read_e0: addr=%h oe_n=%b ce_n=%b ack=%b expected 000092/0/0/0", ram_addr, ram_oe_n, ram_ce_n, bus.ack);
    end
    @(posedge clk); // after E1
    checks++;
    if (ram_oe_n !== 1'b0 || bus.ack !== 1'b0) begin
      errors++; $display("FAIL read_e1: oe_n=%b ack=%b expected 0/0", ram_oe_n, bus.ack);
    end
    @(posedge clk); // after E2
    checks++;
    if (bus.ack !== 1'b1 || bus.dato !== 16'hBEEF || ram_oe_n !== 1'b1 || ram_ce_n !== 1'b1) begin
      errors++; $display("FAIL read_e2: ack=%b dato=%h oe_n=%b ce_n=%b expected 1/beef/1/1", bus.ack, bus.dato, ram_oe_n, ram_ce_n);
    end
    bus.oe = 1'b0;
    @(posedge clk);
    checks++;
    if (bus.ack !== 1'b0 || bus.dato !== 16'hBEEF) begin
      errors++; $display("FAIL read_pulse: ack=%b dato=%h expected 0/beef", bus.ack, bus.dato);
    end
  endtask

  // One complete transaction with latency, address latch and data checks.
  task automatic access(input bit is_wr, input bit both, input logic [22:0] a,
                        input logic [15:0] d, input logic [1:0] be);
    int n;
    int we_low;
    bit got;
    logic [21:0] wa;
    wa = a[22:1];
    n = 0;
    while (bus.busy !== 1'b0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL idle_wait: busy=%b after %0d cycles expected 0", bus.busy, n);
    end
    bus.addr = a; bus.dati = d;
    bus.oe = !is_wr || both;
    bus.we_hi = is_wr & be[1];
    bus.we_lo = is_wr & be[0];
    got = 1'b0; we_low = 0; n = 0;
    while (!got && n < 12) begin
      @(posedge clk);
      n++;
      if (n == 1) begin
        bus.addr = 23'($urandom);
        bus.dati = 16'($urandom);
      end
      if (ram_we_n === 1'b0) we_low++;
      if (bus.ack === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || n != 3) begin
      errors++; $display("FAIL ack_latency: ack at sample %0d (seen=%0d) expected 3", n, got);
    end
    checks++;
    if (ram_addr !== wa) begin
      errors++; $display("FAIL addr_latch: ram_addr=%h expected %h", ram_addr, wa);
    end
    if (is_wr) begin
      checks++;
      if (we_low != 2 || ram_dq_o !== d) begin
        errors++; $display("FAIL write_strobe: we_n low %0d cycles dq_o=%h expected 2/%h", we_low, ram_dq_o, d);
      end
      if (be[1]) ref_mem[wa[7:0]][15:8] = d[15:8];
      if (be[0]) ref_mem[wa[7:0]][7:0]  = d[7:0];
    end else begin
      checks++;
      if (bus.dato !== ref_mem[wa[7:0]]) begin
        errors++; $display("FAIL read_data: dato=%h expected %h addr=%h", bus.dato, ref_mem[wa[7:0]], wa);
      end
    end
    bus.oe = 1'b0; bus.we_hi = 1'b0; bus.we_lo = 1'b0;
  endtask

  task automatic test_byte_write();
    bus.addr = 23'h000010; bus.dati = 16'h5A00; bus.we_hi = 1'b1;
    @(posedge clk); // after E0
    checks++;
    if (ram_we_n !== 1'b0 || ram_ub_n !== 1'b0 || ram_lb_n !== 1'b1 || ram_dq_o !== 16'h5A00 || ram_dq_oe !== 1'b1 || ram_addr !== 22'h8) begin
      errors++; $display("FAIL bw_e0: we_n=%b ub_n=%b lb_n=%b dq_o=%h dq_oe=%b addr=%h expected 0/0/1/5a00/1/8",
                         ram_we_n, ram_ub_n, ram_lb_n, ram_dq_o, ram_dq_oe, ram_addr);
    end
    @(posedge clk); // after E1
    checks++;
    if (ram_we_n !== 1'b0 || bus.ack !== 1'b0) begin
      errors++; $display("FAIL bw_e1: we_n=%b ack=%b expected 0/0", ram_we_n, bus.ack);
    end
    @(posedge clk); // after E2
    checks++;
    if (ram_we_n !== 1'b1 || bus.ack !== 1'b1 || ram_dq_oe !== 1'b1 || ram_ce_n !== 1'b0) begin
      errors++; $display("FAIL bw_e2: we_n=%b ack=%b dq_oe=%b ce_n=%b expected 1/1/1/0", ram_we_n, bus.ack, ram_dq_oe, ram_ce_n);
    end
    bus.we_hi = 1'b0;
    @(posedge clk); // after E3
    checks++;
    if (ram_dq_oe !== 1'b0 || bus.ack !== 1'b0 || ram_ce_n !== 1'b1 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL bw_e3: dq_oe=%b ack=%b ce_n=%b busy=%b expected 0/0/1/0", ram_dq_oe, bus.ack, ram_ce_n, bus.busy);
    end
    ref_mem[8'h08][15:8] = 8'h5A;
    access(1'b0, 1'b0, 23'h000010, 16'h0000, 2'b00);
  endtask

  task automatic test_simultaneous();
    logic [15:0] expd;
    bus.addr = 23'h000201; bus.dati = 16'h1234; bus.oe = 1'b1; bus.we_lo = 1'b1;
    @(posedge clk);
    checks++;
    if (ram_we_n !== 1'b0 || ram_lb_n !== 1'b0 || ram_ub_n !== 1'b1 || ram_oe_n !== 1'b1) begin
      errors++; $display("FAIL sim_write: we_n=%b lb_n=%b ub_n=%b oe_n=%b expected 0/0/1/1", ram_we_n, ram_lb_n, ram_ub_n, ram_oe_n);
    end
    repeat (2) @(posedge clk);
    checks++;
    if (bus.ack !== 1'b1 || ram_we_n !== 1'b1 || ram_dq_oe !== 1'b1 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL sim_whold: ack=%b we_n=%b dq_oe=%b busy=%b expected 1/1/1/1", bus.ack, ram_we_n, ram_dq_oe, bus.busy);
    end
    ref_mem[8'h00][7:0] = 8'h34;
    expd = ref_mem[8'h00];
    bus.we_lo = 1'b0;
    @(posedge clk);
    checks++;
    if (ram_dq_oe !== 1'b0 || ram_oe_n !== 1'b1) begin
      errors++; $display("FAIL sim_idle: dq_oe=%b oe_n=%b expected 0/1", ram_dq_oe, ram_oe_n);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (bus.ack !== 1'b1 || bus.dato !== expd) begin
      errors++; $display("FAIL sim_read: ack=%b dato=%h expected 1/%h", bus.ack, bus.dato, expd);
    end
    bus.oe = 1'b0;
    @(posedge clk);
    checks++;
    if (contention_cnt != 0) begin
      errors++; $display("FAIL sim_contention: %0d cycles with oe_n=0 and dq_oe=1, expected 0", contention_cnt);
    end
  endtask

  task automatic test_random();
    logic [22:0] a;
    logic [15:0] v;
    bit is_wr;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      sram_mem[i] <= v;
      ref_mem[i] = v;
    end
    @(posedge clk);
    for (int t = 0; t < 80; t++) begin
      a = 23'($urandom);
      a[8:1] = 8'($urandom_range(0, 15));
      is_wr = ($urandom_range(0, 1) == 0);
      access(is_wr, ($urandom_range(0, 3) == 0), a, 16'($urandom), 2'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    checks++;
    if (contention_cnt != 0) begin
      errors++; $display("FAIL rand_contention: %0d cycles with oe_n=0 and dq_oe=1, expected 0", contention_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    int bad;
    repeat (3) @(posedge clk);
    bus.addr = 23'h000040; bus.dati = 16'hCAFE; bus.we_lo = 1'b1; bus.we_hi = 1'b1;
    @(posedge clk); // after E0
    checks++;
    if (ram_we_n !== 1'b0 || ram_dq_oe !== 1'b1) begin
      errors++; $display("FAIL rmw_start: we_n=%b dq_oe=%b expected 0/1", ram_we_n, ram_dq_oe);
    end
    rst = 1'b1; bus.we_lo = 1'b0; bus.we_hi = 1'b0;
    @(posedge clk); // after E1 with reset
    checks++;
    if (ram_we_n !== 1'b1 || ram_dq_oe !== 1'b0 || ram_ce_n !== 1'b1 || bus.ack !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL rmw_abort: we_n=%b dq_oe=%b ce_n=%b ack=%b busy=%b expected 1/0/1/0/0",
                         ram_we_n, ram_dq_oe, ram_ce_n, bus.ack, bus.busy);
    end
    rst = 1'b0;
    bad = 0;
    repeat (4) begin
      @(posedge clk);
      if (bus.ack !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rmw_no_ack: %0d cycles with ack/busy after abort, expected 0", bad);
    end
  endtask

  task automatic test_params();
    logic [10:1] ack_hist;
    logic [8:1]  oe_hist;
    logic [7:1]  busy_hist;
    logic [7:6]  ce_hist;
    logic [15:0] dato5, expd;
    expd = 16'h01FF ^ 16'hA5C3;
    ack_hist = '0; oe_hist = '0; busy_hist = '0; ce_hist = '0; dato5 = 16'h0;
    bus2.addr = 23'h0003FE; bus2.oe = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      ack_hist[n] = bus2.ack;
      if (n <= 8) oe_hist[n] = ram_oe_n2;
      if (n <= 7) busy_hist[n] = bus2.busy;
      if (n == 6 || n == 7) ce_hist[n] = ram_ce_n2;
      if (n == 5) dato5 = bus2.dato;
    end
    bus2.oe = 1'b0;
    checks++;
    if (ack_hist !== 10'b00_0001_0000) begin
      errors++; $display("FAIL par_ack: ack history %b expected 0000010000", ack_hist);
    end
    checks++;
    if (dato5 !== expd) begin
      errors++; $display("FAIL par_dato: dato=%h expected %h", dato5, expd);
    end
    checks++;
    if (oe_hist !== 8'b0111_0000 || ce_hist !== 2'b11) begin
      errors++; $display("FAIL par_oe: oe_n history %b ce_n %b expected 01110000/11", oe_hist, ce_hist);
    end
    checks++;
    if (busy_hist !== 7'b011_1111) begin
      errors++; $display("FAIL par_busy: busy history %b expected 0111111", busy_hist);
    end
    repeat (12) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.addr = 23'h0; bus.dati = 16'h0; bus.oe = 1'b0; bus.we_lo = 1'b0; bus.we_hi = 1'b0;
    bus2.addr = 23'h0; bus2.dati = 16'h0; bus2.oe = 1'b0; bus2.we_lo = 1'b0; bus2.we_hi = 1'b0;
    for (int i = 0; i < 256; i++) begin
      sram_mem[i] <= 16'h0000;
      ref_mem[i] = 16'h0000;
    end
    test_reset();
    test_read();
    test_byte_write();
    test_simultaneous();
    test_random();
    test_reset_mid_write();
    test_params();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
